// File: rtl/auction_pkg.sv
// Shared types and constants for the sequential sealed-bid auction engine.
// Optional feature macro: AUCTION_RESERVE_EN (reserve price / no-sale output).
package auction_pkg;

  // Auction controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Pricing mode encodings for the mode input
  localparam logic MODE_FIRST  = 1'b0;
  localparam logic MODE_SECOND = 1'b1;

endpackage

// File: rtl/seq_auction_rank_update.sv
// auction_rank_update: combinational next-value of the running top-two ranking.
// The first beat of an auction (cnt==0) seeds the ranking. A bid equal to the
// current best only competes for second place, so the earliest bidder keeps
// ties.
import auction_pkg::*;

module auction_rank_update #(
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic [W-1:0]  bid,
  input  logic [W-1:0]  best,
  input  logic [W-1:0]  second,
  input  logic [IW-1:0] best_idx,
  input  logic [IW-1:0] cnt,
  output logic [W-1:0]  best_nx,
  output logic [W-1:0]  second_nx,
  output logic [IW-1:0] best_idx_nx
);

  // Insert the new bid into the (best, second) pair
  always_comb begin
    best_nx     = best;
    second_nx   = second;
    best_idx_nx = best_idx;
    if (cnt == '0) begin
      best_nx     = bid;
      best_idx_nx = '0;
      second_nx   = '0;
    end else if (bid > best) begin
      second_nx   = best;
      best_nx     = bid;
      best_idx_nx = cnt;
    end else if (bid > second) begin
      second_nx   = bid;
    end
  end

endmodule

// File: rtl/seq_auction.sv
// seq_auction: streaming sealed-bid auction. One bid per beat, in bidder order.
// Tracks best/second on the fly and reports winner, winning bid and clearing
// price (first-price or second-price, chosen per auction).
// Optional feature macro: AUCTION_RESERVE_EN adds a reserve price input and a
// no_sale output.
import auction_pkg::*;

module seq_auction #(
  parameter int NB = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(NB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic          bid_valid,
  output logic          bid_ready,
  input  logic [W-1:0]  bid_data,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] winner,
  output logic [W-1:0]  winning_bid,
  output logic [W-1:0]  price,
  output logic          tie
`ifdef AUCTION_RESERVE_EN
  ,
  input  logic [W-1:0]  reserve,
  output logic          no_sale
`endif
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  best_q, best_d;
  logic [W-1:0]  second_q, second_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [IW-1:0] winner_q, winner_d;
  logic [W-1:0]  winning_bid_q, winning_bid_d;
  logic [W-1:0]  price_q, price_d;
  logic          tie_q, tie_d;
`ifdef AUCTION_RESERVE_EN
  logic [W-1:0]  reserve_q, reserve_d;
  logic          no_sale_q, no_sale_d;
`endif

  logic [W-1:0]  best_nx, second_nx;
  logic [IW-1:0] best_idx_nx;
  logic          accept;

  auction_rank_update #(.W(W), .IW(IW)) u_rank (
    .bid         (bid_data),
    .best        (best_q),
    .second      (second_q),
    .best_idx    (best_idx_q),
    .cnt         (cnt_q),
    .best_nx     (best_nx),
    .second_nx   (second_nx),
    .best_idx_nx (best_idx_nx)
  );

  assign accept = (state_q == COLLECT) && bid_valid;

  // Next-state, ranking and result-load logic
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    best_d        = best_q;
    second_d      = second_q;
    best_idx_d    = best_idx_q;
    winner_d      = winner_q;
    winning_bid_d = winning_bid_q;
    price_d       = price_q;
    tie_d         = tie_q;
`ifdef AUCTION_RESERVE_EN
    reserve_d     = reserve_q;
    no_sale_d     = no_sale_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          mode_d     = mode;
          cnt_d      = '0;
          best_d     = '0;
          second_d   = '0;
          best_idx_d = '0;
`ifdef AUCTION_RESERVE_EN
          reserve_d  = reserve;
`endif
        end
      end
      COLLECT: begin
        if (accept) begin
          best_d     = best_nx;
          second_d   = second_nx;
          best_idx_d = best_idx_nx;
          if (cnt_q == LAST_IDX) begin
            state_d       = DONE;
            // Results come straight from the updated ranking so the final
            // beat is included without an extra cycle.
            winner_d      = best_idx_nx;
            winning_bid_d = best_nx;
            tie_d         = (best_nx == second_nx);
            price_d       = (mode_q == MODE_SECOND) ? second_nx : best_nx;
`ifdef AUCTION_RESERVE_EN
            if (best_nx < reserve_q) begin
              no_sale_d = 1'b1;
              winner_d  = '0;
              price_d   = '0;
            end else begin
              no_sale_d = 1'b0;
              if (mode_q == MODE_SECOND)
                price_d = (second_nx > reserve_q) ? second_nx : reserve_q;
            end
`endif
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial auction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      cnt_q         <= '0;
      best_q        <= '0;
      second_q      <= '0;
      best_idx_q    <= '0;
      winner_q      <= '0;
      winning_bid_q <= '0;
      price_q       <= '0;
      tie_q         <= 1'b0;
`ifdef AUCTION_RESERVE_EN
      reserve_q     <= '0;
      no_sale_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      best_q        <= best_d;
      second_q      <= second_d;
      best_idx_q    <= best_idx_d;
      winner_q      <= winner_d;
      winning_bid_q <= winning_bid_d;
      price_q       <= price_d;
      tie_q         <= tie_d;
`ifdef AUCTION_RESERVE_EN
      reserve_q     <= reserve_d;
      no_sale_q     <= no_sale_d;
`endif
    end
  end

  assign bid_ready   = (state_q == COLLECT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign winner      = winner_q;
  assign winning_bid = winning_bid_q;
  assign price       = price_q;
  assign tie         = tie_q;
`ifdef AUCTION_RESERVE_EN
  assign no_sale     = no_sale_q;
`endif

endmodule

// File: tb/tb_seq_auction.sv
// Scoreboard bench for seq_auction (NB=4, W=8). Directed auctions push their
// hand-computed results into a queue; a monitor pops one entry per done pulse.
// Build with AUCTION_RESERVE_EN defined to exercise the reserve-price feature.
module tb_seq_auction;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic       bid_valid;
  logic       bid_ready;
  logic [7:0] bid_data;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic [7:0] winning_bid;
  logic [7:0] price;
  logic       tie;
`ifdef AUCTION_RESERVE_EN
  logic [7:0] reserve;
  logic       no_sale;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int prev_wbid  = 0;

  typedef struct {
    int w;
    int wb;
    int p;
    int t;
    int ns;
  } exp_t;

  exp_t exp_q[$];

  seq_auction #(.NB(4), .W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .bid_valid   (bid_valid),
    .bid_ready   (bid_ready),
    .bid_data    (bid_data),
    .busy        (busy),
    .done        (done),
    .winner      (winner),
    .winning_bid (winning_bid),
    .price       (price),
    .tie         (tie)
`ifdef AUCTION_RESERVE_EN
    ,
    .reserve     (reserve),
    .no_sale     (no_sale)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("winner", int'(winner), e.w);
        check("winning_bid", int'(winning_bid), e.wb);
        check("price", int'(price), e.p);
        check("tie", int'(tie), e.t);
`ifdef AUCTION_RESERVE_EN
        check("no_sale", int'(no_sale), e.ns);
`endif
        $display("auction done: winner=%0d winning_bid=%0d price=%0d tie=%0d",
                 winner, winning_bid, price, tie);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic run(input logic m, input logic [7:0] b0, b1, b2, b3,
                     input int maxgap, input bit poke, input logic [7:0] res,
                     input int ew, ewb, ep, et, ens);
    logic [7:0] bids [4];
    exp_t e;
    bids[0] = b0; bids[1] = b1; bids[2] = b2; bids[3] = b3;
    e.w = ew; e.wb = ewb; e.p = ep; e.t = et; e.ns = ens;
    wait_idle();
    check("ready_idle", int'(bid_ready), 0);
    exp_q.push_back(e);
    start = 1'b1;
    mode  = m;
`ifdef AUCTION_RESERVE_EN
    reserve = res;
`else
    if (res != 8'd0) $display("note: reserve %0d ignored in this build", res);
`endif
    @(posedge clk); #1;
    start = poke;
    mode  = ~m;
    check("ready_after_start", int'(bid_ready), 1);
    check("outputs_hold_at_start", int'(winning_bid), prev_wbid);
    for (int i = 0; i < 4; i++) begin
      int gap;
      int n;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
      bid_valid = 1'b1;
      bid_data  = bids[i];
      n = 0;
      while (!bid_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!bid_ready) check("ready_timeout", 1, 0);
      @(posedge clk); #1;
      bid_valid = 1'b0;
      bid_data  = 8'hxx;
    end
    start = 1'b0;
    check("done_latency", int'(done), 1);
    prev_wbid = ewb;
    $display("vector mode=%0d bids=%0d,%0d,%0d,%0d gap<=%0d poke=%0d res=%0d",
             m, b0, b1, b2, b3, maxgap, poke, res);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_ready"}, int'(bid_ready), 0);
    check({tag, "_winner"}, int'(winner), 0);
    check({tag, "_wbid"}, int'(winning_bid), 0);
    check({tag, "_price"}, int'(price), 0);
    check({tag, "_tie"}, int'(tie), 0);
`ifdef AUCTION_RESERVE_EN
    check({tag, "_no_sale"}, int'(no_sale), 0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    bid_valid = 1'b0;
    bid_data  = 8'd0;
`ifdef AUCTION_RESERVE_EN
    reserve   = 8'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // mode, bids, maxgap, poke, reserve, winner, winning_bid, price, tie, no_sale
    run(1'b0, 8'd5, 8'd9, 8'd3, 8'd7, 0, 0, 8'd0, 1, 9, 9, 0, 0);
    run(1'b1, 8'd5, 8'd9, 8'd3, 8'd7, 0, 0, 8'd0, 1, 9, 7, 0, 0);
    run(1'b1, 8'd6, 8'd9, 8'd9, 8'd2, 0, 0, 8'd0, 1, 9, 9, 1, 0);
    run(1'b0, 8'd6, 8'd9, 8'd9, 8'd2, 3, 1, 8'd0, 1, 9, 9, 1, 0);
    run(1'b1, 8'd5, 8'd9, 8'd3, 8'd7, 3, 1, 8'd0, 1, 9, 7, 0, 0);
    run(1'b1, 8'd10, 8'd3, 8'd8, 8'd1, 2, 0, 8'd0, 0, 10, 8, 0, 0);
    run(1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 0, 0, 8'd0, 3, 4, 4, 0, 0);
    run(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 0, 0, 8'd0, 3, 4, 3, 0, 0);
    run(1'b1, 8'd255, 8'd254, 8'd1, 8'd255, 0, 0, 8'd0, 0, 255, 255, 1, 0);
    run(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1, 0, 8'd0, 0, 0, 0, 1, 0);

    // Reset in the middle of an auction after two accepted beats
    run(1'b0, 8'd5, 8'd9, 8'd3, 8'd7, 0, 0, 8'd0, 1, 9, 9, 0, 0);
    wait_idle();
    start = 1'b1;
    mode  = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    bid_valid = 1'b1;
    bid_data  = 8'd8;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bid_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_cleared("midreset");
    @(posedge clk); #1;
    check_cleared("midreset_hold");
    rst_n     = 1'b1;
    prev_wbid = 0;
    $display("vector mid-auction reset after 2 beats");
    run(1'b0, 8'd1, 8'd1, 8'd1, 8'd1, 0, 0, 8'd0, 0, 1, 1, 1, 0);

`ifdef AUCTION_RESERVE_EN
    run(1'b1, 8'd5, 8'd9, 8'd3, 8'd7, 0, 0, 8'd8, 1, 9, 8, 0, 0);
    run(1'b1, 8'd5, 8'd9, 8'd3, 8'd7, 0, 0, 8'd10, 0, 9, 0, 0, 1);
    run(1'b0, 8'd5, 8'd9, 8'd3, 8'd7, 0, 0, 8'd8, 1, 9, 9, 0, 0);
    run(1'b1, 8'd5, 8'd9, 8'd3, 8'd7, 0, 0, 8'd6, 1, 9, 7, 0, 0);
`endif

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
